// File: rtl/jtag_pkg.sv
// Shared types and defaults for the parametrised JTAG TAP.
//   tap_state_t : 16-state 1149.1 TAP controller encoding (4 bits)
//   dr_sel_t    : which data register sits between TDI and TDO
//   *_DEF       : default 4-bit opcodes used when the TAP is not overridden
//   is_shift()  : true in the two states that drive TDO
package jtag_pkg;

  localparam int unsigned ID_LEN     = 32;
  localparam int unsigned DEF_IR_LEN = 4;

  localparam logic [DEF_IR_LEN-1:0] OP_EXTEST_DEF = 4'b0000;
  localparam logic [DEF_IR_LEN-1:0] OP_SAMPLE_DEF = 4'b0001;
  localparam logic [DEF_IR_LEN-1:0] OP_IDCODE_DEF = 4'b0010;

  typedef enum logic [3:0] {
    ST_TLR    = 4'h0,
    ST_RTI    = 4'h1,
    ST_SEL_DR = 4'h2,
    ST_CAP_DR = 4'h3,
    ST_SH_DR  = 4'h4,
    ST_EX1_DR = 4'h5,
    ST_PA_DR  = 4'h6,
    ST_EX2_DR = 4'h7,
    ST_UPD_DR = 4'h8,
    ST_SEL_IR = 4'h9,
    ST_CAP_IR = 4'hA,
    ST_SH_IR  = 4'hB,
    ST_EX1_IR = 4'hC,
    ST_PA_IR  = 4'hD,
    ST_EX2_IR = 4'hE,
    ST_UPD_IR = 4'hF
  } tap_state_t;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_BSR    = 2'd2
  } dr_sel_t;

  // True while the TAP is shifting either the IR or a DR.
  function automatic logic is_shift(input tap_state_t s);
    return (s == ST_SH_DR) || (s == ST_SH_IR);
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller state machine.
// Ports:
//   TCLK, TRST (sync, active high), TMS    : test clock, reset, mode select
//   state_o                                : current TAP state
//   cap_dr_o .. upd_ir_o                   : one-hot, high while in the named state
//                                            (the action happens on the edge leaving it)
//   tlr_c                                  : combinational, the coming edge lands in
//                                            Test-Logic-Reset through TMS
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCLK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_t state_o,
  output logic       cap_dr_o,
  output logic       sh_dr_o,
  output logic       upd_dr_o,
  output logic       cap_ir_o,
  output logic       sh_ir_o,
  output logic       upd_ir_o,
  output logic       tlr_c
);

  tap_state_t state_q;
  tap_state_t state_d;
  logic       cap_dr_q;
  logic       sh_dr_q;
  logic       upd_dr_q;
  logic       cap_ir_q;
  logic       sh_ir_q;
  logic       upd_ir_q;

  // Standard 1149.1 transition table.
  function automatic tap_state_t next_state(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = s;
    case (s)
      ST_TLR:    n = tms ? ST_TLR    : ST_RTI;
      ST_RTI:    n = tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: n = tms ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: n = tms ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  n = tms ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: n = tms ? ST_UPD_DR : ST_PA_DR;
      ST_PA_DR:  n = tms ? ST_EX2_DR : ST_PA_DR;
      ST_EX2_DR: n = tms ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: n = tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: n = tms ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: n = tms ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  n = tms ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: n = tms ? ST_UPD_IR : ST_PA_IR;
      ST_PA_IR:  n = tms ? ST_EX2_IR : ST_PA_IR;
      ST_EX2_IR: n = tms ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: n = tms ? ST_SEL_DR : ST_RTI;
      default:   n = ST_TLR;
    endcase
    return n;
  endfunction

  assign state_d = next_state(state_q, TMS);
  assign tlr_c   = (state_d == ST_TLR);

  // State register with strobes decoded from the next state so they are flops.
  always_ff @(posedge TCLK) begin
    if (TRST) begin
      state_q  <= ST_TLR;
      cap_dr_q <= 1'b0;
      sh_dr_q  <= 1'b0;
      upd_dr_q <= 1'b0;
      cap_ir_q <= 1'b0;
      sh_ir_q  <= 1'b0;
      upd_ir_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cap_dr_q <= (state_d == ST_CAP_DR);
      sh_dr_q  <= (state_d == ST_SH_DR);
      upd_dr_q <= (state_d == ST_UPD_DR);
      cap_ir_q <= (state_d == ST_CAP_IR);
      sh_ir_q  <= (state_d == ST_SH_IR);
      upd_ir_q <= (state_d == ST_UPD_IR);
    end
  end

  assign state_o  = state_q;
  assign cap_dr_o = cap_dr_q;
  assign sh_dr_o  = sh_dr_q;
  assign upd_dr_o = upd_dr_q;
  assign cap_ir_o = cap_ir_q;
  assign sh_ir_o  = sh_ir_q;
  assign upd_ir_o = upd_ir_q;

endmodule

// File: rtl/jtag_tap_param.sv
// Parametrised 1149.1 test access port: TAP FSM, IR with decode, bypass,
// IDCODE and a BSR_LEN-cell boundary-scan register with update stage.
// Ports:
//   TCLK, TRST        : test clock, synchronous active-high reset
//   TMS, TDI          : TAP mode select and serial data in
//   TDO, TDO_EN       : serial data out (from flops) and its enable while shifting
//   bsr_capture       : pin/core values captured in Capture-DR
//   bsr_update        : BSR update stage driving the pad mux
//   bsr_mode          : high while EXTEST is the active instruction
//   ir_active         : current instruction
module jtag_tap_param
  import jtag_pkg::*;
#(
  parameter int unsigned         BSR_LEN    = 77,
  parameter int unsigned         IR_LEN     = DEF_IR_LEN,
  parameter logic [ID_LEN-1:0]   IDCODE_VAL = 32'h0000_0001,
  parameter logic [IR_LEN-1:0]   OP_EXTEST  = IR_LEN'(OP_EXTEST_DEF),
  parameter logic [IR_LEN-1:0]   OP_SAMPLE  = IR_LEN'(OP_SAMPLE_DEF),
  parameter logic [IR_LEN-1:0]   OP_IDCODE  = IR_LEN'(OP_IDCODE_DEF)
) (
  input  logic               TCLK,
  input  logic               TRST,
  input  logic               TMS,
  input  logic               TDI,
  output logic               TDO,
  output logic               TDO_EN,
  input  logic [BSR_LEN-1:0] bsr_capture,
  output logic [BSR_LEN-1:0] bsr_update,
  output logic               bsr_mode,
  output logic [IR_LEN-1:0]  ir_active
);

  tap_state_t fsm_state;
  logic       cap_dr;
  logic       sh_dr;
  logic       upd_dr;
  logic       cap_ir;
  logic       sh_ir;
  logic       upd_ir;
  logic       tlr_c;

  logic [IR_LEN-1:0]  ir_sr_q,     ir_sr_d;
  logic [IR_LEN-1:0]  ir_active_q, ir_active_d;
  logic               byp_q,       byp_d;
  logic [ID_LEN-1:0]  id_sr_q,     id_sr_d;
  logic [BSR_LEN-1:0] bsr_sr_q,    bsr_sr_d;
  logic [BSR_LEN-1:0] bsr_upd_q,   bsr_upd_d;
  logic               bsr_mode_q;
  dr_sel_t            dr_sel;

  jtag_tap_fsm u_fsm (
    .TCLK     (TCLK),
    .TRST     (TRST),
    .TMS      (TMS),
    .state_o  (fsm_state),
    .cap_dr_o (cap_dr),
    .sh_dr_o  (sh_dr),
    .upd_dr_o (upd_dr),
    .cap_ir_o (cap_ir),
    .sh_ir_o  (sh_ir),
    .upd_ir_o (upd_ir),
    .tlr_c    (tlr_c)
  );

  // Instruction decode; every opcode not listed falls through to bypass.
  always_comb begin
    dr_sel = DR_BYPASS;
    if ((ir_active_q == OP_EXTEST) || (ir_active_q == OP_SAMPLE)) begin
      dr_sel = DR_BSR;
    end else if (ir_active_q == OP_IDCODE) begin
      dr_sel = DR_IDCODE;
    end
  end

  // Next-state for IR, the data registers and the BSR update stage.
  always_comb begin
    ir_sr_d     = ir_sr_q;
    ir_active_d = ir_active_q;
    byp_d       = byp_q;
    id_sr_d     = id_sr_q;
    bsr_sr_d    = bsr_sr_q;
    bsr_upd_d   = bsr_upd_q;

    if (cap_ir) begin
      ir_sr_d = IR_LEN'(1);
    end
    if (sh_ir) begin
      ir_sr_d = {TDI, ir_sr_q[IR_LEN-1:1]};
    end
    if (upd_ir) begin
      ir_active_d = ir_sr_q;
    end
    // Walking into Test-Logic-Reset restores IDCODE but leaves data regs alone.
    if (tlr_c) begin
      ir_active_d = OP_IDCODE;
    end

    if (cap_dr) begin
      case (dr_sel)
        DR_BSR:    bsr_sr_d = bsr_capture;
        DR_IDCODE: id_sr_d  = IDCODE_VAL;
        default:   byp_d    = 1'b0;
      endcase
    end
    if (sh_dr) begin
      case (dr_sel)
        DR_BSR:    bsr_sr_d = {TDI, bsr_sr_q[BSR_LEN-1:1]};
        DR_IDCODE: id_sr_d  = {TDI, id_sr_q[ID_LEN-1:1]};
        default:   byp_d    = TDI;
      endcase
    end
    if (upd_dr && (dr_sel == DR_BSR)) begin
      bsr_upd_d = bsr_sr_q;
    end
  end

  // Register bank; bsr_mode tracks the instruction being written this edge.
  always_ff @(posedge TCLK) begin
    if (TRST) begin
      ir_sr_q     <= '0;
      ir_active_q <= OP_IDCODE;
      byp_q       <= 1'b0;
      id_sr_q     <= IDCODE_VAL;
      bsr_sr_q    <= '0;
      bsr_upd_q   <= '0;
      bsr_mode_q  <= 1'b0;
    end else begin
      ir_sr_q     <= ir_sr_d;
      ir_active_q <= ir_active_d;
      byp_q       <= byp_d;
      id_sr_q     <= id_sr_d;
      bsr_sr_q    <= bsr_sr_d;
      bsr_upd_q   <= bsr_upd_d;
      bsr_mode_q  <= (ir_active_d == OP_EXTEST);
    end
  end

  // TDO mux driven purely from flops.
  always_comb begin
    TDO = 1'b0;
    if (sh_ir) begin
      TDO = ir_sr_q[0];
    end else if (sh_dr) begin
      case (dr_sel)
        DR_BSR:    TDO = bsr_sr_q[0];
        DR_IDCODE: TDO = id_sr_q[0];
        default:   TDO = byp_q;
      endcase
    end
  end

  assign TDO_EN     = is_shift(fsm_state);
  assign bsr_update = bsr_upd_q;
  assign bsr_mode   = bsr_mode_q;
  assign ir_active  = ir_active_q;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Bench for jtag_tap_param: directed scans followed by a random TMS/TDI walk,
// every edge checked against a queue-based model of the TAP.
module tb_jtag_tap_param;

  localparam int          BSR_N = 77;
  localparam int          IRN   = 4;
  localparam logic [31:0] IDV   = 32'h0000_0001;
  localparam logic [3:0]  OPE   = 4'b0000;
  localparam logic [3:0]  OPS   = 4'b0001;
  localparam logic [3:0]  OPI   = 4'b0010;

  localparam int S_TLR = 0,  S_RTI = 1,  S_SDR = 2,  S_CDR = 3;
  localparam int S_SHDR = 4, S_E1DR = 5, S_PDR = 6,  S_E2DR = 7;
  localparam int S_UDR = 8,  S_SIR = 9,  S_CIR = 10, S_SHIR = 11;
  localparam int S_E1IR = 12, S_PIR = 13, S_E2IR = 14, S_UIR = 15;

  // Next state for TMS=0 / TMS=1, indexed by the bench's own state numbering.
  int nx0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nx1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  typedef logic bitq_t[$];

  logic             TCLK;
  logic             TRST;
  logic             TMS;
  logic             TDI;
  logic             TDO;
  logic             TDO_EN;
  logic [BSR_N-1:0] bsr_capture;
  logic [BSR_N-1:0] bsr_update;
  logic             bsr_mode;
  logic [IRN-1:0]   ir_active;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  int           m_state;
  logic [3:0]   m_ir_act;
  logic [BSR_N-1:0] m_upd;
  bitq_t        q_ir, q_bsr, q_id, q_byp;

  jtag_tap_param dut (
    .TCLK        (TCLK),
    .TRST        (TRST),
    .TMS         (TMS),
    .TDI         (TDI),
    .TDO         (TDO),
    .TDO_EN      (TDO_EN),
    .bsr_capture (bsr_capture),
    .bsr_update  (bsr_update),
    .bsr_mode    (bsr_mode),
    .ir_active   (ir_active)
  );

  initial TCLK = 1'b0;
  always #5 TCLK = ~TCLK;

  function automatic bitq_t to_q(input logic [127:0] v, input int n);
    bitq_t q;
    for (int i = 0; i < n; i++) q.push_back(v[i]);
    return q;
  endfunction

  function automatic logic [127:0] from_q(input bitq_t q);
    logic [127:0] v = '0;
    for (int i = 0; i < q.size(); i++) v[i] = q[i];
    return v;
  endfunction

  // 0 = bypass, 1 = idcode, 2 = boundary scan
  function automatic int dr_of(input logic [3:0] op);
    if (op == OPE || op == OPS) return 2;
    if (op == OPI) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model one edge, clock the DUT, then compare all outputs.
  task automatic step(input logic tms, input logic tdi, input logic trst);
    int   sel;
    logic e_tdo;
    logic e_en;
    TMS = tms;
    TDI = tdi;
    TRST = trst;
    if (trst) begin
      m_state  = S_TLR;
      m_ir_act = OPI;
      m_upd    = '0;
      q_ir     = to_q('0, IRN);
      q_bsr    = to_q('0, BSR_N);
      q_id     = to_q(128'(IDV), 32);
      q_byp    = to_q('0, 1);
    end else begin
      sel = dr_of(m_ir_act);
      case (m_state)
        S_CIR:  q_ir = to_q(128'd1, IRN);
        S_SHIR: begin void'(q_ir.pop_front()); q_ir.push_back(tdi); end
        S_UIR:  m_ir_act = 4'(from_q(q_ir));
        S_CDR: begin
          if (sel == 2)      q_bsr = to_q(128'(bsr_capture), BSR_N);
          else if (sel == 1) q_id  = to_q(128'(IDV), 32);
          else               q_byp = to_q('0, 1);
        end
        S_SHDR: begin
          if (sel == 2)      begin void'(q_bsr.pop_front()); q_bsr.push_back(tdi); end
          else if (sel == 1) begin void'(q_id.pop_front());  q_id.push_back(tdi);  end
          else               begin void'(q_byp.pop_front()); q_byp.push_back(tdi); end
        end
        S_UDR: if (sel == 2) m_upd = BSR_N'(from_q(q_bsr));
        default: ;
      endcase
      m_state = tms ? nx1[m_state] : nx0[m_state];
      if (m_state == S_TLR) m_ir_act = OPI;
    end

    e_en  = (m_state == S_SHDR) || (m_state == S_SHIR);
    e_tdo = 1'b0;
    if (m_state == S_SHIR) e_tdo = q_ir[0];
    else if (m_state == S_SHDR) begin
      sel = dr_of(m_ir_act);
      if (sel == 2)      e_tdo = q_bsr[0];
      else if (sel == 1) e_tdo = q_id[0];
      else               e_tdo = q_byp[0];
    end

    @(posedge TCLK);
    #1;
    cyc++;
    chk($sformatf("tdo@%0d", cyc),       128'(TDO),        128'(e_tdo));
    chk($sformatf("tdo_en@%0d", cyc),    128'(TDO_EN),     128'(e_en));
    chk($sformatf("bsr_mode@%0d", cyc),  128'(bsr_mode),   128'(m_ir_act == OPE));
    chk($sformatf("ir_active@%0d", cyc), 128'(ir_active),  128'(m_ir_act));
    chk($sformatf("bsr_update@%0d", cyc), 128'(bsr_update), 128'(m_upd));
  endtask

  // From Run-Test/Idle: full DR scan of n bits, back to Run-Test/Idle.
  task automatic scan_dr(input int n, input logic [127:0] din, output logic [127:0] dout);
    dout = '0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    dout[0] = TDO;
    for (int k = 0; k < n; k++) begin
      step(k == n - 1, din[k], 1'b0);
      if (k < n - 1) dout[k+1] = TDO;
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // From Run-Test/Idle: load an instruction, return the captured IR bits.
  task automatic scan_ir(input logic [3:0] op, output logic [3:0] cap);
    cap = '0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    cap[0] = TDO;
    for (int k = 0; k < IRN; k++) begin
      step(k == IRN - 1, op[k], 1'b0);
      if (k < IRN - 1) cap[k+1] = TDO;
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [127:0]     d;
    logic [3:0]       c;
    logic [95:0]      r;
    logic [BSR_N-1:0] pat_cap;
    logic [BSR_N-1:0] pat_pre;
    logic [BSR_N-1:0] pat_ext;

    TRST = 1'b1;
    TMS = 1'b1;
    TDI = 1'b0;
    bsr_capture = '0;
    #2;

    // Reset state
    step(1'b1, 1'b0, 1'b1);
    chk("rst_tdo",    128'(TDO),        '0);
    chk("rst_tdo_en", 128'(TDO_EN),     '0);
    chk("rst_mode",   128'(bsr_mode),   '0);
    chk("rst_update", 128'(bsr_update), '0);
    chk("rst_ir",     128'(ir_active),  128'(OPI));
    step(1'b0, 1'b0, 1'b0);

    // IDCODE read straight after reset
    scan_dr(32, '0, d);
    chk("idcode", 128'(d[31:0]), 128'(IDV));

    // TMS escape from the middle of a DR shift
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    chk("esc_ir",     128'(ir_active), 128'(OPI));
    chk("esc_mode",   128'(bsr_mode),  '0);
    chk("esc_tdo_en", 128'(TDO_EN),    '0);
    step(1'b0, 1'b0, 1'b0);

    // IR capture pattern and bypass latency
    scan_ir(4'b1111, c);
    chk("ir_capture", 128'(c), 128'(4'b0001));
    scan_dr(4, 128'(4'b1101), d);
    chk("bypass", 128'(d[3:0]), 128'(4'b1010));

    // SAMPLE/PRELOAD
    pat_cap = 77'h1_5A5A_5A5A_5A5A_5A5A_5A5;
    pat_pre = 77'h0F0F_0F0F_0F0F_0F0F_0F0;
    bsr_capture = pat_cap;
    scan_ir(OPS, c);
    scan_dr(BSR_N, 128'(pat_pre), d);
    chk("sample_out",  128'(d[BSR_N-1:0]), 128'(pat_cap));
    chk("preload",     128'(bsr_update),   128'(pat_pre));
    chk("sample_mode", 128'(bsr_mode),     '0);

    // EXTEST: mode on the UPD_IR edge, update stage held until UPD_DR
    scan_ir(OPE, c);
    chk("extest_mode", 128'(bsr_mode),   128'(1));
    chk("extest_hold", 128'(bsr_update), 128'(pat_pre));
    r = {$urandom(), $urandom(), $urandom()};
    pat_ext = r[BSR_N-1:0];
    r = {$urandom(), $urandom(), $urandom()};
    bsr_capture = r[BSR_N-1:0];
    scan_dr(BSR_N, 128'(pat_ext), d);
    chk("extest_cap", 128'(d[BSR_N-1:0]), 128'(r[BSR_N-1:0]));
    chk("extest_upd", 128'(bsr_update),   128'(pat_ext));
    scan_ir(OPI, c);
    chk("ir_change_mode", 128'(bsr_mode),   '0);
    chk("ir_change_hold", 128'(bsr_update), 128'(pat_ext));

    // Undefined opcode behaves as bypass
    scan_ir(4'b0110, c);
    scan_dr(4, 128'(4'b1101), d);
    chk("undef_bypass", 128'(d[3:0]), 128'(4'b1010));

    // Synchronous TRST in the middle of an IR shift
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    chk("trst_tdo",    128'(TDO),       '0);
    chk("trst_tdo_en", 128'(TDO_EN),    '0);
    chk("trst_ir",     128'(ir_active), 128'(OPI));
    step(1'b0, 1'b0, 1'b0);

    // Random walk over the whole state graph
    repeat (2500) begin
      r = {$urandom(), $urandom(), $urandom()};
      bsr_capture = r[BSR_N-1:0];
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 299) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jtag_tap_param.md
Name: jtag_tap_param

Overview:
- Parametrised IEEE 1149.1-style test access port for scan-wrapped benchmark cores.
- Integrates in one block: TAP FSM, instruction register, instruction decode, bypass register, IDCODE register and a boundary-scan register of configurable length.
- Sits between the chip-level TDI/TMS/TDO pins and the core's functional I/O.
- Adds SAMPLE/PRELOAD, IDCODE and EXTEST pin control.

Parameters:
- BSR_LEN, 77: number of boundary-scan cells (core inputs + outputs).
- IR_LEN, 4: instruction register width (>=2).
- IDCODE_VAL, 32'h0000_0001: 32-bit device ID; bit0 must be 1.
- OP_EXTEST, 4'b0000: EXTEST opcode (IR_LEN bits).
- OP_SAMPLE, 4'b0001: SAMPLE/PRELOAD opcode.
- OP_IDCODE, 4'b0010: IDCODE opcode.
- BYPASS: all-ones opcode, fixed. Any undefined opcode decodes as BYPASS.

Ports:
- TCLK input 1: test clock. The only clock; all state updates on the rising edge.
- TRST input 1: synchronous, active-high reset.
- TMS input 1: test mode select.
- TDI input 1: serial data in.
- TDO output 1: serial data out.
- TDO_EN output 1: high while in Shift-DR or Shift-IR.
- bsr_capture input BSR_LEN: parallel values sampled at Capture-DR (pin/core side).
- bsr_update output BSR_LEN: BSR update-stage register contents.
- bsr_mode output 1: 1 while EXTEST is active; pad mux then selects bsr_update.
- ir_active output IR_LEN: current (updated) instruction.

Behaviour:
- Reset: on a rising TCLK edge with TRST=1:
  - FSM -> TEST_LOGIC_RESET.
  - ir_active <= OP_IDCODE; IR shift reg <= 0; bypass bit <= 0; BSR shift and update regs <= 0; IDCODE shift reg <= IDCODE_VAL.
  - Outputs: TDO=0, TDO_EN=0, bsr_mode=0, bsr_update=0.
  - TRST overrides TMS and any mid-shift operation.
- FSM: the standard 16-state TAP (TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, and the IR mirror set). Transitions follow 1149.1 on TMS at each rising edge.
  - TLR: TMS=0 -> RTI, else stay.
  - SEL_IR with TMS=1 -> TLR.
  - UPD_x: TMS=1 -> SEL_DR, TMS=0 -> RTI.
- Five consecutive TMS=1 edges reach TLR from any state.
- Entering TLR by TMS has the same effect as TRST on ir_active (-> IDCODE) and bsr_mode (-> 0). Shift and update registers are untouched in that case.
- State actions take effect on the edge that leaves the named state:
  - CAP_IR: IR shift reg <= {0..0,01}.
  - SH_IR: IR shift reg <= {TDI, sr[IR_LEN-1:1]}.
  - UPD_IR: ir_active <= IR shift reg.
  - CAP_DR (selected DR only): BSR shift <= bsr_capture; IDCODE shift <= IDCODE_VAL; bypass <= 0.
  - SH_DR: selected DR shifts right, TDI enters the MSB. Bypass is a 1-bit register.
  - UPD_DR: if the instruction is EXTEST or SAMPLE, bsr_update <= BSR shift. Otherwise no effect.
- DR selection:
  - EXTEST and SAMPLE -> BSR.
  - IDCODE -> IDCODE register.
  - All other opcodes -> bypass.
- TDO: combinational from flops. In SH_IR it is the IR shift reg bit0; in SH_DR it is the selected DR bit0; otherwise 0. TDO_EN mirrors this.
- Latency: the TDI->TDO path through bypass is exactly 1 TCLK. Through the BSR it is BSR_LEN clocks; through the IR it is IR_LEN clocks.
- bsr_mode = (ir_active==OP_EXTEST). It changes on the UPD_IR edge.
- Pause states (PA_DR, PA_IR) hold all shift registers.
- Changing IR while in EXTEST holds bsr_update until the next UPD_DR.

Decomposition:
- Package jtag_pkg:
  - tap_state_t enum (16 states, 4-bit encoding).
  - Default opcode localparams.
  - Helper function is_shift(state).
- Sub-module jtag_tap_fsm:
  - Inputs: TCLK, TRST, TMS.
  - Outputs: state, plus one-hot strobes cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir, tlr.
  - The top holds IR, decode, bypass, IDCODE, BSR and the TDO mux.

Test Plan:
- Reset/IDCODE: assert TRST 1 cycle, then TMS 0,1,0,0 (RTI->SEL_DR->CAP_DR->SH_DR), then shift 32 with TDI=0 -> TDO serial equals IDCODE_VAL LSB-first (1 then 0...).
- TMS escape: from SH_DR mid-shift, drive TMS=1 for 5 edges -> state TLR, ir_active=OP_IDCODE, bsr_mode=0.
- IR capture/bypass: load IR 4'b1111 (shift TDI=1x4) -> first 4 TDO bits read 1,0,0,0. Then in SH_DR, TDI pattern 1,0,1,1 -> TDO 0,1,0,1 (1-cycle delay).
- SAMPLE/PRELOAD: bsr_capture=77'h1_5A5A...; load OP_SAMPLE; capture and shift 77 -> TDO reproduces the pattern LSB-first. Shift in 77'h0F..., UPD_DR -> bsr_update=77'h0F..., bsr_mode=0.
- EXTEST: after preload, load OP_EXTEST -> bsr_mode=1 on the UPD_IR edge, and bsr_update unchanged until the next UPD_DR.
- Undefined opcode 4'b0110 -> behaves as bypass (1-cycle TDI->TDO). Sync TRST asserted during SH_IR -> next edge TLR, TDO=0, TDO_EN=0.
